// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register for the 5-stage RISC-V core.
// Captures decoded operands and control for EX. On a load-use hazard it
// inserts one bubble and freezes PC and IF/ID. On a taken branch resolved
// in EX it squashes the ID instruction. Results being written back in the
// same cycle are bypassed into the captured operands.
// Optional feature macro: HAZARD_STATS_EN (adds saturating stall/flush counters).
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              ex_flush,
    input  logic              wb_regwrite,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              idexe_valid,
    output logic [XLEN-1:0]   idexe_pc,
    output logic [XLEN-1:0]   idexe_rs1_data,
    output logic [XLEN-1:0]   idexe_rs2_data,
    output logic [XLEN-1:0]   idexe_imm,
    output logic [4:0]        idexe_rs1,
    output logic [4:0]        idexe_rs2,
    output logic [4:0]        idexe_rd,
    output logic [CTRL_W-1:0] idexe_ctrl,
    output logic              stall_if_id
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    // Bit position of MemRead inside the control bundle.
    localparam int CTRL_MEMREAD = 1;

    logic              hazard_s;
    logic              bubble_s;
    logic              nxt_valid_s;
    logic [XLEN-1:0]   nxt_pc_s;
    logic [XLEN-1:0]   nxt_rs1_data_s;
    logic [XLEN-1:0]   nxt_rs2_data_s;
    logic [XLEN-1:0]   nxt_imm_s;
    logic [4:0]        nxt_rs1_s;
    logic [4:0]        nxt_rs2_s;
    logic [4:0]        nxt_rd_s;
    logic [CTRL_W-1:0] nxt_ctrl_s;

    // Load-use detection: a load in EX whose rd (non-x0) is read by ID.
    always_comb begin
        hazard_s    = 1'b0;
        stall_if_id = 1'b0;
        if (idexe_valid && idexe_ctrl[CTRL_MEMREAD] && (idexe_rd != 5'd0) && id_valid &&
            ((idexe_rd == id_rs1) || (idexe_rd == id_rs2))) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = 1'b0;
        end
        // A flush squashes ID anyway, so there is nothing to hold; reset also drops the stall.
        if (rst || ex_flush) begin
            stall_if_id = 1'b0;
        end else begin
            stall_if_id = hazard_s;
        end
    end

    // Next-state selection: bubble on flush or hazard, else capture ID with WB bypass.
    always_comb begin
        bubble_s       = ex_flush | hazard_s;
        nxt_valid_s    = 1'b0;
        nxt_pc_s       = {XLEN{1'b0}};
        nxt_rs1_data_s = {XLEN{1'b0}};
        nxt_rs2_data_s = {XLEN{1'b0}};
        nxt_imm_s      = {XLEN{1'b0}};
        nxt_rs1_s      = 5'd0;
        nxt_rs2_s      = 5'd0;
        nxt_rd_s       = 5'd0;
        nxt_ctrl_s     = {CTRL_W{1'b0}};
        if (bubble_s) begin
            nxt_valid_s = 1'b0;
        end else begin
            nxt_valid_s = id_valid;
            nxt_pc_s    = id_pc;
            nxt_imm_s   = id_imm;
            nxt_rs1_s   = id_rs1;
            nxt_rs2_s   = id_rs2;
            nxt_rd_s    = id_rd;
            // An invalid slot must never carry side-effecting control into EX.
            if (id_valid) begin
                nxt_ctrl_s = id_ctrl;
            end else begin
                nxt_ctrl_s = {CTRL_W{1'b0}};
            end
            // The register file is read before WB writes it, so patch in the WB value.
            if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == id_rs1)) begin
                nxt_rs1_data_s = wb_data;
            end else begin
                nxt_rs1_data_s = id_rs1_data;
            end
            if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == id_rs2)) begin
                nxt_rs2_data_s = wb_data;
            end else begin
                nxt_rs2_data_s = id_rs2_data;
            end
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            idexe_valid    <= 1'b0;
            idexe_pc       <= {XLEN{1'b0}};
            idexe_rs1_data <= {XLEN{1'b0}};
            idexe_rs2_data <= {XLEN{1'b0}};
            idexe_imm      <= {XLEN{1'b0}};
            idexe_rs1      <= 5'd0;
            idexe_rs2      <= 5'd0;
            idexe_rd       <= 5'd0;
            idexe_ctrl     <= {CTRL_W{1'b0}};
        end else begin
            idexe_valid    <= nxt_valid_s;
            idexe_pc       <= nxt_pc_s;
            idexe_rs1_data <= nxt_rs1_data_s;
            idexe_rs2_data <= nxt_rs2_data_s;
            idexe_imm      <= nxt_imm_s;
            idexe_rs1      <= nxt_rs1_s;
            idexe_rs2      <= nxt_rs2_s;
            idexe_rd       <= nxt_rd_s;
            idexe_ctrl     <= nxt_ctrl_s;
        end
    end

`ifdef HAZARD_STATS_EN
    // Saturating event counters for stalls and squashed real instructions.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (stall_if_id && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (ex_flush && id_valid && (flush_cnt != 32'hFFFF_FFFF)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 8;

    logic              clk;
    logic              rst;
    logic              id_valid;
    logic [XLEN-1:0]   id_pc;
    logic [XLEN-1:0]   id_rs1_data;
    logic [XLEN-1:0]   id_rs2_data;
    logic [XLEN-1:0]   id_imm;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic [4:0]        id_rd;
    logic [CTRL_W-1:0] id_ctrl;
    logic              ex_flush;
    logic              wb_regwrite;
    logic [4:0]        wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              idexe_valid;
    logic [XLEN-1:0]   idexe_pc;
    logic [XLEN-1:0]   idexe_rs1_data;
    logic [XLEN-1:0]   idexe_rs2_data;
    logic [XLEN-1:0]   idexe_imm;
    logic [4:0]        idexe_rs1;
    logic [4:0]        idexe_rs2;
    logic [4:0]        idexe_rd;
    logic [CTRL_W-1:0] idexe_ctrl;
    logic              stall_if_id;
`ifdef HAZARD_STATS_EN
    logic [31:0]       stall_cnt;
    logic [31:0]       flush_cnt;
    logic [31:0]       exp_stall;
    logic [31:0]       exp_flush;
`endif

    int checks;
    int failures;

    id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_ctrl(id_ctrl),
        .ex_flush(ex_flush), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .idexe_valid(idexe_valid), .idexe_pc(idexe_pc), .idexe_rs1_data(idexe_rs1_data),
        .idexe_rs2_data(idexe_rs2_data), .idexe_imm(idexe_imm), .idexe_rs1(idexe_rs1),
        .idexe_rs2(idexe_rs2), .idexe_rd(idexe_rd), .idexe_ctrl(idexe_ctrl),
        .stall_if_id(stall_if_id)
`ifdef HAZARD_STATS_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [4:0] rd, input logic [7:0] ctrl,
                            input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm);
        id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_ctrl = ctrl; id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
    endtask

    task automatic test_reset();
        rst = 1'b1; ex_flush = 1'b0; wb_regwrite = 1'b1; wb_rd = 5'd3; wb_data = $urandom;
        drive_id(1'b1, $urandom, 5'($urandom), 5'($urandom), 5'($urandom), 8'hFF,
                 $urandom, $urandom, $urandom);
        tick(); tick();
        checks++; if (idexe_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", idexe_valid); end
        checks++; if (idexe_ctrl !== 8'h00) begin failures++; $display("FAIL reset_ctrl got=%h exp=00", idexe_ctrl); end
        checks++; if (idexe_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", idexe_pc); end
        checks++; if ({idexe_rs1_data, idexe_rs2_data, idexe_imm} !== 96'h0) begin failures++; $display("FAIL reset_data got=%h/%h/%h exp=0", idexe_rs1_data, idexe_rs2_data, idexe_imm); end
        checks++; if ({idexe_rs1, idexe_rs2, idexe_rd} !== 15'h0) begin failures++; $display("FAIL reset_idx got=%h exp=0", {idexe_rs1, idexe_rs2, idexe_rd}); end
        checks++; if (stall_if_id !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_if_id); end
`ifdef HAZARD_STATS_EN
        exp_stall = 32'd0; exp_flush = 32'd0;
        checks++; if ({stall_cnt, flush_cnt} !== 64'h0) begin failures++; $display("FAIL reset_cnt got=%h/%h exp=0", stall_cnt, flush_cnt); end
`endif
        rst = 1'b0; wb_regwrite = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
    endtask

    task automatic test_normal();
        drive_id(1'b1, 32'h100, 5'd5, 5'd6, 5'd7, 8'h11, 32'hAAAA, 32'hBBBB, 32'h4);
        tick();
        checks++; if (idexe_pc !== 32'h100) begin failures++; $display("FAIL normal_pc got=%h exp=100", idexe_pc); end
        checks++; if (idexe_rs1 !== 5'd5 || idexe_rs2 !== 5'd6 || idexe_rd !== 5'd7) begin failures++; $display("FAIL normal_idx got=%0d/%0d/%0d exp=5/6/7", idexe_rs1, idexe_rs2, idexe_rd); end
        checks++; if (idexe_ctrl !== 8'h11) begin failures++; $display("FAIL normal_ctrl got=%h exp=11", idexe_ctrl); end
        checks++; if (idexe_valid !== 1'b1) begin failures++; $display("FAIL normal_valid got=%b exp=1", idexe_valid); end
        checks++; if (idexe_rs1_data !== 32'hAAAA || idexe_rs2_data !== 32'hBBBB || idexe_imm !== 32'h4) begin failures++; $display("FAIL normal_data got=%h/%h/%h exp=aaaa/bbbb/4", idexe_rs1_data, idexe_rs2_data, idexe_imm); end
        // Invalid slot: fields captured, control forced to zero.
        drive_id(1'b0, 32'h200, 5'd1, 5'd2, 5'd3, 8'hFF, 32'h1, 32'h2, 32'h3);
        tick();
        checks++; if (idexe_valid !== 1'b0 || idexe_ctrl !== 8'h00) begin failures++; $display("FAIL invalid_ctrl got=%b/%h exp=0/00", idexe_valid, idexe_ctrl); end
        checks++; if (idexe_pc !== 32'h200) begin failures++; $display("FAIL invalid_pc got=%h exp=200", idexe_pc); end
    endtask

    task automatic test_load_use();
        drive_id(1'b1, 32'h300, 5'd1, 5'd2, 5'd5, 8'h0B, 32'h0, 32'h0, 32'h8);
        tick();
        // Matching index but ID slot invalid: no stall.
        drive_id(1'b0, 32'h304, 5'd6, 5'd5, 5'd8, 8'h81, 32'h11, 32'h22, 32'h0);
        #1;
        checks++; if (stall_if_id !== 1'b0) begin failures++; $display("FAIL lu_invalid_stall got=%b exp=0", stall_if_id); end
        id_valid = 1'b1;
        #1;
        checks++; if (stall_if_id !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", stall_if_id); end
        tick();
        checks++; if (idexe_valid !== 1'b0 || idexe_ctrl !== 8'h00 || idexe_pc !== 32'h0 || idexe_rd !== 5'd0) begin failures++; $display("FAIL lu_bubble got=%b/%h/%h/%0d exp=0/00/0/0", idexe_valid, idexe_ctrl, idexe_pc, idexe_rd); end
        checks++; if (stall_if_id !== 1'b0) begin failures++; $display("FAIL lu_stall_clear got=%b exp=0", stall_if_id); end
        tick();
        checks++; if (idexe_pc !== 32'h304 || idexe_ctrl !== 8'h81 || idexe_valid !== 1'b1 || idexe_rs2 !== 5'd5) begin failures++; $display("FAIL lu_capture got=%h/%h/%b/%0d exp=304/81/1/5", idexe_pc, idexe_ctrl, idexe_valid, idexe_rs2); end
        checks++; if (stall_if_id !== 1'b0) begin failures++; $display("FAIL lu_after_stall got=%b exp=0", stall_if_id); end
`ifdef HAZARD_STATS_EN
        exp_stall = exp_stall + 32'd1;
        checks++; if (stall_cnt !== exp_stall) begin failures++; $display("FAIL lu_stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall); end
`endif
    endtask

    task automatic test_x0_load();
        drive_id(1'b1, 32'h400, 5'd1, 5'd2, 5'd0, 8'h0B, 32'h0, 32'h0, 32'h0);
        tick();
        drive_id(1'b1, 32'h404, 5'd0, 5'd0, 5'd9, 8'h01, 32'h0, 32'h0, 32'h0);
        #1;
        checks++; if (stall_if_id !== 1'b0) begin failures++; $display("FAIL x0_stall got=%b exp=0", stall_if_id); end
        tick();
        checks++; if (idexe_pc !== 32'h404 || idexe_valid !== 1'b1) begin failures++; $display("FAIL x0_capture got=%h/%b exp=404/1", idexe_pc, idexe_valid); end
    endtask

    task automatic test_flush_hazard();
        drive_id(1'b1, 32'h500, 5'd1, 5'd2, 5'd9, 8'h0B, 32'h0, 32'h0, 32'h0);
        tick();
        drive_id(1'b1, 32'h504, 5'd9, 5'd3, 5'd10, 8'h01, 32'h5, 32'h6, 32'h0);
        ex_flush = 1'b1;
        #1;
        checks++; if (stall_if_id !== 1'b0) begin failures++; $display("FAIL fh_stall got=%b exp=0", stall_if_id); end
        tick();
        checks++; if (idexe_valid !== 1'b0 || idexe_ctrl !== 8'h00 || idexe_pc !== 32'h0 || idexe_rs1_data !== 32'h0) begin failures++; $display("FAIL fh_bubble got=%b/%h/%h/%h exp=0/00/0/0", idexe_valid, idexe_ctrl, idexe_pc, idexe_rs1_data); end
`ifdef HAZARD_STATS_EN
        exp_flush = exp_flush + 32'd1;
        checks++; if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin failures++; $display("FAIL fh_cnt got=%0d/%0d exp=%0d/%0d", stall_cnt, flush_cnt, exp_stall, exp_flush); end
`endif
        // Plain flush of a non-hazard instruction.
        drive_id(1'b1, 32'h508, 5'd4, 5'd4, 5'd4, 8'h11, 32'h7, 32'h7, 32'h7);
        tick();
        checks++; if (idexe_valid !== 1'b0 || idexe_pc !== 32'h0 || idexe_rd !== 5'd0) begin failures++; $display("FAIL flush_bubble got=%b/%h/%0d exp=0/0/0", idexe_valid, idexe_pc, idexe_rd); end
`ifdef HAZARD_STATS_EN
        exp_flush = exp_flush + 32'd1;
        checks++; if (flush_cnt !== exp_flush) begin failures++; $display("FAIL flush_cnt got=%0d exp=%0d", flush_cnt, exp_flush); end
`endif
        ex_flush = 1'b0;
    endtask

    task automatic test_wb_bypass();
        wb_regwrite = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD;
        drive_id(1'b1, 32'h600, 5'd3, 5'd4, 5'd8, 8'h01, 32'h0, 32'h1234, 32'h0);
        tick();
        checks++; if (idexe_rs1_data !== 32'hDEAD || idexe_rs2_data !== 32'h1234) begin failures++; $display("FAIL wb_rs1 got=%h/%h exp=dead/1234", idexe_rs1_data, idexe_rs2_data); end
        wb_rd = 5'd0;
        drive_id(1'b1, 32'h604, 5'd0, 5'd4, 5'd8, 8'h01, 32'h0, 32'h1234, 32'h0);
        tick();
        checks++; if (idexe_rs1_data !== 32'h0) begin failures++; $display("FAIL wb_x0 got=%h exp=0", idexe_rs1_data); end
        wb_rd = 5'd4;
        drive_id(1'b1, 32'h608, 5'd3, 5'd4, 5'd8, 8'h01, 32'h0, 32'h1234, 32'h0);
        tick();
        checks++; if (idexe_rs1_data !== 32'h0 || idexe_rs2_data !== 32'hDEAD) begin failures++; $display("FAIL wb_rs2 got=%h/%h exp=0/dead", idexe_rs1_data, idexe_rs2_data); end
        wb_regwrite = 1'b0;
        tick();
        checks++; if (idexe_rs2_data !== 32'h1234) begin failures++; $display("FAIL wb_nowrite got=%h exp=1234", idexe_rs2_data); end
        wb_rd = 5'd0; wb_data = 32'h0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            drive_id(1'b1, 32'h700 + 32'(4 * i), 5'd1, 5'd2, 5'd3, 8'h81, 32'(i * 17), 32'h0, 32'h0);
            tick();
            checks++; if (idexe_pc !== 32'h700 + 32'(4 * i) || idexe_rs1_data !== 32'(i * 17)) begin failures++; $display("FAIL b2b_%0d got=%h/%h exp=%h/%h", i, idexe_pc, idexe_rs1_data, 32'h700 + 32'(4 * i), 32'(i * 17)); end
        end
    endtask

    task automatic test_reset_mid_stall();
        drive_id(1'b1, 32'h800, 5'd1, 5'd2, 5'd12, 8'h0B, 32'h0, 32'h0, 32'h0);
        tick();
        drive_id(1'b1, 32'h804, 5'd12, 5'd2, 5'd13, 8'h01, 32'h0, 32'h0, 32'h0);
        #1;
        checks++; if (stall_if_id !== 1'b1) begin failures++; $display("FAIL rms_pre got=%b exp=1", stall_if_id); end
        rst = 1'b1;
        #1;
        checks++; if (stall_if_id !== 1'b0) begin failures++; $display("FAIL rms_stall got=%b exp=0", stall_if_id); end
        tick();
        checks++; if (idexe_valid !== 1'b0 || idexe_ctrl !== 8'h00) begin failures++; $display("FAIL rms_state got=%b/%h exp=0/00", idexe_valid, idexe_ctrl); end
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_normal();
        test_load_use();
        test_x0_load();
        test_flush_hazard();
        test_wb_bypass();
        test_back_to_back();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
